// File: rtl/butterfly_pkg.sv
// Shared definitions for the butterfly controllers: FSM states, default geometry and counter widths.
package butterfly_pkg;

  localparam int unsigned NUM_OUTPUT_DEF = 8;
  localparam int unsigned MAX_LEN_DEF    = 2048;
  localparam int unsigned REP_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int unsigned word_cnt_w(input int unsigned max_len);
    return $clog2(max_len);
  endfunction

  function automatic int unsigned grp_cnt_w(input int unsigned max_len, input int unsigned num_output,
                                            input int unsigned rep_width);
    return $clog2(max_len / num_output) + rep_width;
  endfunction

  localparam int unsigned WORD_CNT_W = word_cnt_w(MAX_LEN_DEF);
  localparam int unsigned VEC_CNT_W  = REP_WIDTH_DEF;
  localparam int unsigned GRP_CNT_W  = grp_cnt_w(MAX_LEN_DEF, NUM_OUTPUT_DEF, REP_WIDTH_DEF);

endpackage

// File: rtl/butterfly_s2p_ctrl_if.sv
// Descriptor, serial source and s2p-side signals of the butterfly s2p sequencer.
interface butterfly_s2p_ctrl_if
  import butterfly_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned REP_WIDTH  = REP_WIDTH_DEF
);
  logic                  cfg_vld;
  logic                  cfg_rdy;
  logic [31:0]           cfg_length;
  logic [REP_WIDTH-1:0]  cfg_repeat;
  logic [DATA_WIDTH-1:0] src_dat;
  logic                  src_vld;
  logic                  src_rdy;
  logic [DATA_WIDTH-1:0] s2p_up_dat;
  logic                  s2p_up_vld;
  logic [31:0]           s2p_length;
  logic                  s2p_up_rdy;
  logic                  s2p_dn_vld;

  // Environment side: descriptor/source producer and the s2p itself.
  modport master (
    output cfg_vld, cfg_length, cfg_repeat, src_dat, src_vld, s2p_up_rdy, s2p_dn_vld,
    input  cfg_rdy, src_rdy, s2p_up_dat, s2p_up_vld, s2p_length
  );

  // Sequencer side.
  modport slave (
    input  cfg_vld, cfg_length, cfg_repeat, src_dat, src_vld, s2p_up_rdy, s2p_dn_vld,
    output cfg_rdy, src_rdy, s2p_up_dat, s2p_up_vld, s2p_length
  );
endinterface

// File: rtl/butterfly_cfg_check.sv
// Combinational legality check of a butterfly job descriptor (length, repeat).
module butterfly_cfg_check
  import butterfly_pkg::*;
#(
  parameter int unsigned NUM_OUTPUT = NUM_OUTPUT_DEF,
  parameter int unsigned MAX_LEN    = MAX_LEN_DEF,
  parameter int unsigned REP_WIDTH  = REP_WIDTH_DEF
) (
  input  logic [31:0]          length,
  input  logic [REP_WIDTH-1:0] rep,
  output logic                 legal_c
);
  localparam int unsigned LANE_W = $clog2(NUM_OUTPUT);

  always_comb begin
    legal_c = (length != 32'd0)
           && (length[LANE_W-1:0] == LANE_W'(0))
           && (length <= 32'(MAX_LEN))
           && (rep != REP_WIDTH'(0));
  end
endmodule

// File: rtl/butterfly_s2p_ctrl.sv
// Job sequencer for the butterfly s2p: feeds length*repeat serial words, counts emitted groups, pulses done.
module butterfly_s2p_ctrl
  import butterfly_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_OUTPUT = NUM_OUTPUT_DEF,
  parameter int unsigned MAX_LEN    = MAX_LEN_DEF,
  parameter int unsigned REP_WIDTH  = REP_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  butterfly_s2p_ctrl_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int unsigned WORD_W    = word_cnt_w(MAX_LEN);
  localparam int unsigned GRP_W     = grp_cnt_w(MAX_LEN, NUM_OUTPUT, REP_WIDTH);
  localparam int unsigned GRP_SHIFT = $clog2(NUM_OUTPUT);

  state_e                state, state_nxt;
  logic [WORD_W-1:0]     word_cnt, len_m1;
  logic [REP_WIDTH-1:0]  vec_cnt, rep_m1;
  logic [GRP_W-1:0]      grp_cnt, tot_grp;
  logic [31:0]           length_q;
  logic                  dn_prev;

  logic                  cfg_legal_c;
  logic                  cfg_rdy_c, src_rdy_c, up_vld_c;
  logic                  accept_c, reject_c, last_word_c, grp_rise_c, stray_c;
  logic [DATA_WIDTH-1:0] up_dat_c;

  butterfly_cfg_check #(
    .NUM_OUTPUT (NUM_OUTPUT),
    .MAX_LEN    (MAX_LEN),
    .REP_WIDTH  (REP_WIDTH)
  ) u_cfg_check (
    .length  (bus.cfg_length),
    .rep     (bus.cfg_repeat),
    .legal_c (cfg_legal_c)
  );

  // Next state and handshake decode.
  always_comb begin
    state_nxt   = state;
    cfg_rdy_c   = 1'b0;
    src_rdy_c   = 1'b0;
    up_vld_c    = 1'b0;
    up_dat_c    = bus.src_dat;
    accept_c    = 1'b0;
    reject_c    = 1'b0;
    last_word_c = (word_cnt == len_m1) && (vec_cnt == rep_m1);
    grp_rise_c  = bus.s2p_dn_vld && !dn_prev;
    // A group beyond the expected total (or any group while idle) is flagged but never blocks the job.
    stray_c     = grp_rise_c && ((state == IDLE) || (grp_cnt >= tot_grp));
    case (state)
      IDLE: begin
        cfg_rdy_c = 1'b1;
        accept_c  = bus.cfg_vld && cfg_legal_c;
        reject_c  = bus.cfg_vld && !cfg_legal_c;
        if (accept_c) state_nxt = RUN;
      end
      RUN: begin
        src_rdy_c = bus.s2p_up_rdy;
        up_vld_c  = bus.src_vld && bus.s2p_up_rdy;
        if (up_vld_c && last_word_c) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Wait for the final group to land and drop before declaring completion.
        if ((grp_cnt >= tot_grp) && !bus.s2p_dn_vld) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, descriptor latches and word/vector/group counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_cnt <= '0;
      vec_cnt  <= '0;
      len_m1   <= '0;
      rep_m1   <= '0;
      tot_grp  <= '0;
      grp_cnt  <= '0;
      length_q <= '0;
      dn_prev  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state   <= state_nxt;
      dn_prev <= bus.s2p_dn_vld;
      err     <= reject_c || stray_c;
      if (accept_c) begin
        length_q <= bus.cfg_length;
        len_m1   <= WORD_W'(bus.cfg_length - 32'd1);
        rep_m1   <= bus.cfg_repeat - REP_WIDTH'(1);
        tot_grp  <= GRP_W'(bus.cfg_length >> GRP_SHIFT) * GRP_W'(bus.cfg_repeat);
        word_cnt <= '0;
        vec_cnt  <= '0;
        grp_cnt  <= '0;
      end else begin
        if (up_vld_c) begin
          if (word_cnt == len_m1) begin
            word_cnt <= '0;
            vec_cnt  <= vec_cnt + REP_WIDTH'(1);
          end else begin
            word_cnt <= word_cnt + WORD_W'(1);
          end
        end
        if (grp_rise_c && (grp_cnt != '1)) grp_cnt <= grp_cnt + GRP_W'(1);
      end
    end
  end

  assign bus.cfg_rdy    = cfg_rdy_c;
  assign bus.src_rdy    = src_rdy_c;
  assign bus.s2p_up_vld = up_vld_c;
  assign bus.s2p_up_dat = up_dat_c;
  assign bus.s2p_length = length_q;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_butterfly_s2p_ctrl.sv
// Bench for butterfly_s2p_ctrl: behavioural s2p/source model, directed jobs and randomized jobs.
module tb_butterfly_s2p_ctrl;
  import butterfly_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned NO    = 8;
  localparam int unsigned ML    = 2048;
  localparam int unsigned RW    = 16;
  localparam int          STALL = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, done, err;

  always #5 clk = ~clk;

  butterfly_s2p_ctrl_if #(.DATA_WIDTH(DW), .REP_WIDTH(RW)) bus ();

  butterfly_s2p_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_OUTPUT (NO),
    .MAX_LEN    (ML),
    .REP_WIDTH  (RW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor-owned observations (cumulative; tasks work on differences).
  int          cyc = 0;
  bit          xfer_now = 1'b0, src_now = 1'b0, dn_prev_tb = 1'b0;
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] tx_q[$];
  int          xfer_cyc[$];
  int          done_cnt = 0, err_cnt = 0, busy_cnt = 0, grp_seen = 0, len_chg = 0, bad_xfer = 0;
  int          done_cyc = 0, last_dn = 0;
  logic [31:0] len_prev = 32'd0;

  // Main-owned controls.
  bit          fast = 1'b0;
  int          stall_tok = 0, stray_tok = 0;
  logic [31:0] model_len = 32'd0;

  // Driver-owned state.
  int          stall_seen = 0, stray_seen = 0, stall_left = 0, wcount = 0, hold = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample everything mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    xfer_now = rst_n && bus.s2p_up_vld && bus.s2p_up_rdy;
    src_now  = rst_n && bus.src_vld && bus.src_rdy;
    if (xfer_now) begin
      rx_q.push_back(bus.s2p_up_dat);
      xfer_cyc.push_back(cyc);
    end
    if (src_now) tx_q.push_back(bus.src_dat);
    if (bus.s2p_up_vld && !busy) bad_xfer++;
    if (bus.s2p_dn_vld && !dn_prev_tb) grp_seen++;
    dn_prev_tb = bus.s2p_dn_vld;
    if (bus.s2p_dn_vld) last_dn = cyc;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
    if (busy) busy_cnt++;
    if (bus.s2p_length !== len_prev) len_chg++;
    len_prev = bus.s2p_length;
  end

  // Serial source and behavioural s2p: one group (dn_vld pulse or held level) per NO accepted words.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      wcount = 0; hold = 0; stall_left = 0;
      bus.s2p_dn_vld = 1'b0; bus.s2p_up_rdy = 1'b0;
      bus.src_vld = 1'b0; bus.src_dat = '0;
    end else begin
      if (xfer_now) wcount++;
      if (bus.s2p_dn_vld) begin
        if (hold > 1) hold--;
        else begin bus.s2p_dn_vld = 1'b0; hold = 0; end
      end else if (wcount >= int'(NO)) begin
        wcount = 0;
        bus.s2p_dn_vld = 1'b1;
        hold = (stall_tok != stall_seen) ? STALL : (fast ? 1 : int'($urandom_range(1, 3)));
      end
      if (stray_tok != stray_seen) begin
        stray_seen = stray_tok; bus.s2p_dn_vld = 1'b1; hold = 1;
      end
      if (stall_tok != stall_seen) begin
        stall_seen = stall_tok; stall_left = STALL;
      end
      if (stall_left > 0) begin
        bus.s2p_up_rdy = 1'b0; stall_left--;
      end else begin
        bus.s2p_up_rdy = fast ? 1'b1 : (!bus.s2p_dn_vld && ($urandom_range(0, 3) != 0));
      end
      if (src_now || !bus.src_vld) bus.src_dat = DW'($urandom);
      bus.src_vld = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_cfg(input logic [31:0] len, input logic [RW-1:0] rep);
    @(posedge clk); #1;
    bus.cfg_vld = 1'b1; bus.cfg_length = len; bus.cfg_repeat = rep;
    @(posedge clk); #1;
    bus.cfg_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_len = 32'd0;
  endtask

  task automatic run_job(input int len, input int rep, input bit stall);
    int rx0, g0, d0, e0, l0, b0, exp_n, mism;
    bit got_done;
    rx0 = rx_q.size(); g0 = grp_seen; d0 = done_cnt; e0 = err_cnt; l0 = len_chg; b0 = bad_xfer;
    exp_n = len * rep; got_done = 1'b0; mism = 0;
    send_cfg(32'(len), RW'(rep));
    if (stall) begin
      for (int i = 0; i < 2000 && (rx_q.size() - rx0) < 8; i++) @(posedge clk);
      stall_tok++;
    end
    for (int i = 0; i < exp_n * 8 + 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got_done = 1'b1; break; end
    end
    chk("done_seen", 64'(got_done), 64'(1));
    if (!got_done) begin do_reset(); return; end
    chk("cfg_rdy_in_done", 64'(bus.cfg_rdy), 64'(0));
    @(negedge clk);
    chk("cfg_rdy_after_done", 64'(bus.cfg_rdy), 64'(1));
    chk("busy_after_done", 64'(busy), 64'(0));
    @(posedge clk);
    chk("xfer_count", 64'(rx_q.size() - rx0), 64'(exp_n));
    for (int i = rx0; i < rx_q.size() && i < tx_q.size(); i++) if (rx_q[i] !== tx_q[i]) mism++;
    chk("data_passthru", 64'(mism + (rx_q.size() - tx_q.size())), 64'(0));
    chk("groups", 64'(grp_seen - g0), 64'(exp_n / int'(NO)));
    chk("done_pulses", 64'(done_cnt - d0), 64'(1));
    chk("done_after_last_group", 64'(done_cyc - last_dn), 64'(2));
    chk("no_err", 64'(err_cnt - e0), 64'(0));
    chk("len_changes", 64'(len_chg - l0), 64'(32'(len) != model_len));
    chk("s2p_length", 64'(bus.s2p_length), 64'(len));
    chk("no_xfer_outside_run", 64'(bad_xfer - b0), 64'(0));
    if (fast && rx_q.size() > rx0)
      chk("xfer_span", 64'(xfer_cyc[$] - xfer_cyc[rx0] + 1), 64'(exp_n + (stall ? STALL : 0)));
    model_len = 32'(len);
  endtask

  task automatic bad_cfg(input logic [31:0] len, input logic [RW-1:0] rep);
    int e0, b0;
    e0 = err_cnt; b0 = busy_cnt;
    send_cfg(len, rep);
    repeat (4) @(posedge clk);
    chk("bad_cfg_err", 64'(err_cnt - e0), 64'(1));
    chk("bad_cfg_busy", 64'(busy_cnt - b0), 64'(0));
    chk("bad_cfg_len", 64'(bus.s2p_length), 64'(model_len));
  endtask

  initial begin
    int rx0, d0, e0, b0;
    rst_n = 1'b0;
    bus.cfg_vld = 1'b0; bus.cfg_length = '0; bus.cfg_repeat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_rdy", 64'(bus.cfg_rdy), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_s2p_length", 64'(bus.s2p_length), 64'(0));
    chk("rst_src_rdy", 64'(bus.src_rdy), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Streaming job, then the same job with a 5-cycle s2p stall after word 7.
    fast = 1'b1;
    run_job(16, 2, 1'b0);
    run_job(16, 2, 1'b1);
    fast = 1'b0;

    // Rejected descriptors.
    bad_cfg(32'd12, RW'(1));
    bad_cfg(32'd0, RW'(1));
    bad_cfg(32'd4096, RW'(1));
    bad_cfg(32'd16, RW'(0));

    // Back-to-back jobs.
    run_job(8, 1, 1'b0);
    run_job(24, 3, 1'b0);

    // Reset in the middle of a job, then a fresh job.
    rx0 = rx_q.size(); d0 = done_cnt;
    send_cfg(32'd16, RW'(2));
    for (int i = 0; i < 2000 && (rx_q.size() - rx0) < 11; i++) @(posedge clk);
    do_reset();
    @(negedge clk);
    chk("midrst_cfg_rdy", 64'(bus.cfg_rdy), 64'(1));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_s2p_length", 64'(bus.s2p_length), 64'(0));
    repeat (20) @(posedge clk);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'(0));
    run_job(16, 1, 1'b0);

    // Stray group while idle.
    repeat (3) @(posedge clk);
    e0 = err_cnt; b0 = busy_cnt;
    stray_tok++;
    repeat (6) @(posedge clk);
    chk("stray_err", 64'(err_cnt - e0), 64'(1));
    chk("stray_busy", 64'(busy_cnt - b0), 64'(0));
    @(negedge clk);
    chk("stray_cfg_rdy", 64'(bus.cfg_rdy), 64'(1));

    // Randomized legal jobs.
    for (int j = 0; j < 4; j++)
      run_job(int'(NO) * int'($urandom_range(1, 8)), int'($urandom_range(1, 3)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
